// File: rtl/la_varb2_pkg.sv
// la_varb2_pkg: shared state and source encodings for the la_varb2 arbiter.
package la_varb2_pkg;

  // Packet-lock FSM states (only used when LA_VARB2_LOCK_EN is defined)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  // One-hot source / grant encodings
  localparam logic [1:0] SRC_IN0 = 2'b01;
  localparam logic [1:0] SRC_IN1 = 2'b10;

endpackage

// File: rtl/la_varb2_mux.sv
// la_varb2_mux: two-input one-hot vector mux, out = sel0?in0 : sel1?in1 : 0.
// PROP names the cell flavour; "DEFAULT" uses a plain vector AND-OR,
// anything else uses a per-bit gate form that a library mapping can bind to.
module la_varb2_mux #(
  parameter int N    = 1,
  parameter     PROP = "DEFAULT"
) (
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic         sel0,
  input  logic         sel1,
  output logic [N-1:0] out
);

  if (PROP == "DEFAULT") begin : g_generic
    assign out = ({N{sel0}} & in0) | ({N{sel1}} & in1);
  end else begin : g_bitwise
    for (genvar b = 0; b < N; b++) begin : g_bit
      assign out[b] = (sel0 & in0[b]) | (sel1 & in1[b]);
    end
  end

endmodule

// File: rtl/la_varb2.sv
// la_varb2: two-requester round-robin arbiter with a one-entry registered
// output stage. Define LA_VARB2_LOCK_EN to hold the grant for a whole packet
// (until a beat with last=1); otherwise every beat is treated as last.
module la_varb2
  import la_varb2_pkg::*;
#(
  parameter int N    = 1,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  input  logic [N-1:0] in0_data,
  input  logic         in0_last,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [N-1:0] in1_data,
  input  logic         in1_last,
  output logic         in1_ready,
  output logic         sel0,
  output logic         sel1,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [1:0]   out_src,
  input  logic         out_ready
);

  logic         r_out_valid;
  logic [N-1:0] r_out_data;
  logic [1:0]   r_out_src;
  logic         r_ptr;        // 1 = in1 favoured on a tie

  logic [1:0]   w_valid;
  logic [1:0]   w_grant_arb;
  logic [1:0]   w_grant;
  logic         w_space;
  logic         w_xfer;
  logic [N-1:0] w_mux;

  assign w_valid = {in1_valid, in0_valid};
  assign w_space = ~r_out_valid | out_ready;

  // Round-robin choice among the currently valid requesters
  always_comb begin
    w_grant_arb = '0;
    if (&w_valid) w_grant_arb = r_ptr ? SRC_IN1 : SRC_IN0;
    else          w_grant_arb = w_valid;
  end

`ifdef LA_VARB2_LOCK_EN
  state_t r_state;
  logic   w_last;

  // Locked owner overrides the arbiter, even when it has no beat this cycle
  always_comb begin
    w_grant = '0;
    if (!rst) begin
      unique case (r_state)
        ST_LOCK0: w_grant = SRC_IN0;
        ST_LOCK1: w_grant = SRC_IN1;
        default:  w_grant = w_grant_arb;
      endcase
    end
  end

  assign w_last = (w_grant[0] & in0_last) | (w_grant[1] & in1_last);

  // Packet-lock FSM; pointer rotates only when a packet completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_state <= ST_IDLE;
        r_ptr   <= w_grant[0];
      end else begin
        r_state <= w_grant[0] ? ST_LOCK0 : ST_LOCK1;
      end
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = in0_last ^ in1_last;

  // Plain arbitration, grant suppressed during reset
  always_comb begin
    w_grant = '0;
    if (!rst) w_grant = w_grant_arb;
  end

  // Last winner drops to lowest priority after every transfer
  always_ff @(posedge clk) begin
    if (rst)         r_ptr <= 1'b0;
    else if (w_xfer) r_ptr <= w_grant[0];
  end
`endif

  assign w_xfer    = (|(w_grant & w_valid)) & w_space;
  assign sel0      = w_grant[0];
  assign sel1      = w_grant[1];
  assign in0_ready = w_grant[0] & w_space;
  assign in1_ready = w_grant[1] & w_space;

  la_varb2_mux #(
    .N    (N),
    .PROP (PROP)
  ) u_mux (
    .in0  (in0_data),
    .in1  (in1_data),
    .sel0 (w_grant[0]),
    .sel1 (w_grant[1]),
    .out  (w_mux)
  );

  // One-entry output register: fill on transfer, empty when drained
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux;
      r_out_src   <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_la_varb2.sv
// tb_la_varb2: randomized scoreboard bench for la_varb2 (N=4).
module tb_la_varb2;

  localparam int N = 4;
`ifdef LA_VARB2_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in0_valid, in0_last, in0_ready;
  logic         in1_valid, in1_last, in1_ready;
  logic [N-1:0] in0_data, in1_data;
  logic         sel0, sel1;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  la_varb2 #(.N(N), .PROP("DEFAULT")) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .sel0      (sel0),
    .sel1      (sel1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] data;
    logic [1:0]   src;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model state
  bit           m_full;
  int           m_pref;    // requester favoured on a tie
  int           m_lock;    // -1 = no packet in progress, else owner
  bit           was_rst;
  // Requester-side stimulus state: a pending beat stays up until accepted
  bit           pend [2];
  logic [N-1:0] pdata [2];
  bit           plast [2];
  int           pv_pct [2];
  int           rdy_pct;
  bit           fixed_data;
  bit           want_rst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit sp;
    int w;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && ($urandom_range(99) < pv_pct[i])) begin
        pend[i]  = 1'b1;
        pdata[i] = fixed_data ? ((i == 0) ? 4'hA : 4'h5) : N'($urandom);
        plast[i] = fixed_data ? 1'b1 : ($urandom_range(99) < 40);
      end
    end
    rst       = want_rst;
    in0_valid = pend[0];
    in0_data  = pend[0] ? pdata[0] : N'($urandom);
    in0_last  = plast[0];
    in1_valid = pend[1];
    in1_data  = pend[1] ? pdata[1] : N'($urandom);
    in1_last  = plast[1];
    out_ready = ($urandom_range(99) < rdy_pct);
    #1;
    sp = !m_full || out_ready;
    if (rst)                   w = -1;
    else if (m_lock >= 0)      w = m_lock;
    else if (pend[0] && pend[1]) w = m_pref;
    else if (pend[0])          w = 0;
    else if (pend[1])          w = 1;
    else                       w = -1;
    chk("sel0", sel0, w == 0);
    chk("sel1", sel1, w == 1);
    chk("in0_ready", in0_ready, (w == 0) && sp);
    chk("in1_ready", in1_ready, (w == 1) && sp);
    chk("out_valid", out_valid, m_full);
    if (was_rst) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      was_rst = 1'b0;
    end
    if (rst) begin
      m_full  = 1'b0;
      m_pref  = 0;
      m_lock  = -1;
      was_rst = 1'b1;
      sb_q.delete();
    end else if (w >= 0 && pend[w] && sp) begin
      sb_q.push_back('{data: pdata[w], src: (w == 0) ? 2'b01 : 2'b10});
      m_full = 1'b1;
      if (!LOCK_EN || plast[w]) begin
        m_pref = 1 - w;
        m_lock = -1;
      end else begin
        m_lock = w;
      end
      pend[w] = 1'b0;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
  endtask

  // Monitor: pop and compare whenever the output handshake will happen
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0h src %0h, expected none", out_data, out_src);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_src", out_src, e.src);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0; in0_last = 1'b0; in1_last = 1'b0;
    m_full = 1'b0; m_pref = 0; m_lock = -1; was_rst = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    want_rst = 1'b1; fixed_data = 1'b1;
    pv_pct[0] = 100; pv_pct[1] = 100; rdy_pct = 100;

    // Reset held two cycles with both requesters valid
    repeat (2) cycle();
    want_rst = 1'b0;
    // Alternation A,5,A,5 with continuous drain
    repeat (8) cycle();
    // Backpressure for 3 cycles, then release
    rdy_pct = 0;
    repeat (3) cycle();
    rdy_pct = 100;
    repeat (4) cycle();
    // Single requester in1
    pv_pct[0] = 0;
    repeat (6) cycle();
    // Random data and packet boundaries, both contending
    fixed_data = 1'b0;
    pv_pct[0] = 100;
    repeat (30) cycle();
    // Fully random traffic
    pv_pct[0] = 60; pv_pct[1] = 60; rdy_pct = 70;
    repeat (2000) cycle();
    // Reset in the middle of traffic
    want_rst = 1'b1;
    cycle();
    want_rst = 1'b0;
    pv_pct[0] = 50; pv_pct[1] = 80; rdy_pct = 60;
    repeat (500) cycle();
    // Drain with a bounded cycle budget
    pv_pct[0] = 0; pv_pct[1] = 0; rdy_pct = 100;
    for (int k = 0; k < 30 && (pend[0] || pend[1] || m_full || sb_q.size() != 0); k++) cycle();
    #5;
    if (pend[0] || pend[1] || sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
